// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared definitions for the MIPS execute stage.
//   - 8-bit decoded ALU op codes
//   - divider FSM state encoding
//   - word / register-address widths and divider step count
package cpu_defs_pkg;

  localparam int unsigned WordW    = 32;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned DivSteps = 32;

  localparam logic [7:0] AluAnd   = 8'h24;
  localparam logic [7:0] AluOr    = 8'h25;
  localparam logic [7:0] AluXor   = 8'h26;
  localparam logic [7:0] AluNor   = 8'h27;
  localparam logic [7:0] AluSll   = 8'h7C;
  localparam logic [7:0] AluSrl   = 8'h02;
  localparam logic [7:0] AluSra   = 8'h03;
  localparam logic [7:0] AluDiv   = 8'h1A;
  localparam logic [7:0] AluDivu  = 8'h1B;
  localparam logic [7:0] AluMult  = 8'h18;
  localparam logic [7:0] AluMultu = 8'h19;

  typedef enum logic [1:0] {
    StDivIdle = 2'd0,
    StDivZero = 2'd1,
    StDivOn   = 2'd2,
    StDivEnd  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider, one quotient bit per cycle.
// Operands are latched at issue; signed ops divide magnitudes and fix signs
// when the result is registered on entry to the end state.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               DIV/DIVU present in the execute stage
//   signed_op           1 = DIV, 0 = DIVU
//   dividend, divisor   operands (sampled only in the issue cycle)
//   annul               flush: abort and return to idle on the next edge
//   busy                stall request (issue, zero-divisor and iterate cycles)
//   done                result valid (end state)
//   quotient, remainder results, zero unless done
module div_unit
  import cpu_defs_pkg::*;
#(
  parameter int unsigned DIV_STEPS = DivSteps
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_op,
  input  logic [31:0]  dividend,
  input  logic [31:0]  divisor,
  input  logic         annul,
  output logic         busy,
  output logic         done,
  output logic [31:0]  quotient,
  output logic [31:0]  remainder
);

  div_state_e  state_q;
  logic [4:0]  cnt_q;
  logic [31:0] dvd_q;   // dividend magnitude shifting out, quotient bits shifting in
  logic [31:0] dsr_q;   // divisor magnitude
  logic [31:0] rem_q;   // partial remainder
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic [31:0] res_quo_q;
  logic [31:0] res_rem_q;

  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        quo_bit;
  logic [31:0] rem_next;
  logic [31:0] dvd_next;

  always_comb begin
    dividend_mag = (signed_op && dividend[31]) ? (32'd0 - dividend) : dividend;
    divisor_mag  = (signed_op && divisor[31])  ? (32'd0 - divisor)  : divisor;
    rem_shift    = {rem_q, dvd_q[31]};
    rem_diff     = rem_shift - {1'b0, dsr_q};
    quo_bit      = ~rem_diff[32];
    rem_next     = quo_bit ? rem_diff[31:0] : rem_shift[31:0];
    dvd_next     = {dvd_q[30:0], quo_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StDivIdle;
      cnt_q     <= 5'd0;
      dvd_q     <= 32'd0;
      dsr_q     <= 32'd0;
      rem_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_quo_q <= 32'd0;
      res_rem_q <= 32'd0;
    end else if (annul) begin
      state_q <= StDivIdle;
    end else begin
      unique case (state_q)
        StDivIdle: begin
          if (start) begin
            dvd_q     <= dividend_mag;
            dsr_q     <= divisor_mag;
            rem_q     <= 32'd0;
            cnt_q     <= 5'd0;
            neg_quo_q <= signed_op && (dividend[31] ^ divisor[31]);
            neg_rem_q <= signed_op && dividend[31];
            state_q   <= (divisor == 32'd0) ? StDivZero : StDivOn;
          end
        end
        StDivZero: begin
          res_quo_q <= 32'd0;
          res_rem_q <= 32'd0;
          state_q   <= StDivEnd;
        end
        StDivOn: begin
          dvd_q <= dvd_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_STEPS - 1)) begin
            res_quo_q <= neg_quo_q ? (32'd0 - dvd_next) : dvd_next;
            res_rem_q <= neg_rem_q ? (32'd0 - rem_next) : rem_next;
            state_q   <= StDivEnd;
          end
        end
        StDivEnd: begin
          state_q <= StDivIdle;
        end
        default: state_q <= StDivIdle;
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    quotient  = 32'd0;
    remainder = 32'd0;
    if (!annul) begin
      busy = ((state_q == StDivIdle) && start) || (state_q == StDivZero) ||
             (state_q == StDivOn);
      done = (state_q == StDivEnd);
    end
    if (done) begin
      quotient  = res_quo_q;
      remainder = res_rem_q;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Combinational logic/shift ALU, iterative DIV/DIVU via div_unit, and the
// GPR / HI-LO writeback muxing. The GPR result also feeds decode forwarding.
// Optional: define EX_MULT_EN to add single-cycle MULT/MULTU.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   aluop_i, reg1_i, reg2_i     decoded op and operands
//   wd_i, wreg_i                destination GPR and write enable
//   flush_i                     abort in-flight instruction
//   wd_o, wreg_o, wdata_o       GPR writeback
//   whilo_o, hi_o, lo_o         HI/LO writeback
//   stall_req_o                 hold PC, IF/ID and ID/EX
module ex_stage
  import cpu_defs_pkg::*;
#(
  parameter int unsigned DIV_STEPS = DivSteps
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   aluop_i,
  input  logic [31:0]  reg1_i,
  input  logic [31:0]  reg2_i,
  input  logic [4:0]   wd_i,
  input  logic         wreg_i,
  input  logic         flush_i,
  output logic [4:0]   wd_o,
  output logic         wreg_o,
  output logic [31:0]  wdata_o,
  output logic         whilo_o,
  output logic [31:0]  hi_o,
  output logic [31:0]  lo_o,
  output logic         stall_req_o
);

  logic        is_div;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  assign is_div = (aluop_i == AluDiv) || (aluop_i == AluDivu);

  div_unit #(
    .DIV_STEPS (DIV_STEPS)
  ) u_div_unit (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .signed_op (aluop_i == AluDiv),
    .dividend  (reg1_i),
    .divisor   (reg2_i),
    .annul     (flush_i),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

`ifdef EX_MULT_EN
  // Sign-extend only for MULT; the low 64 bits of the product are then
  // correct for both signed and unsigned operands with one multiplier.
  logic        mult_sgn;
  logic [63:0] mult_a;
  logic [63:0] mult_b;
  logic [63:0] product;
  assign mult_sgn = (aluop_i == AluMult);
  assign mult_a   = {{32{mult_sgn & reg1_i[31]}}, reg1_i};
  assign mult_b   = {{32{mult_sgn & reg2_i[31]}}, reg2_i};
  assign product  = mult_a * mult_b;
`endif

  always_comb begin
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = 32'd0;
    whilo_o     = 1'b0;
    hi_o        = 32'd0;
    lo_o        = 32'd0;
    stall_req_o = div_busy;

    unique case (aluop_i)
      AluAnd:  wdata_o = reg1_i & reg2_i;
      AluOr:   wdata_o = reg1_i | reg2_i;
      AluXor:  wdata_o = reg1_i ^ reg2_i;
      AluNor:  wdata_o = ~(reg1_i | reg2_i);
      AluSll:  wdata_o = reg2_i << reg1_i[4:0];
      AluSrl:  wdata_o = reg2_i >> reg1_i[4:0];
      AluSra:  wdata_o = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      AluDiv, AluDivu: wreg_o = 1'b0;
`ifdef EX_MULT_EN
      AluMult, AluMultu: begin
        wreg_o  = 1'b0;
        whilo_o = 1'b1;
        hi_o    = product[63:32];
        lo_o    = product[31:0];
      end
`endif
      default: ;
    endcase

    if (div_done) begin
      whilo_o = 1'b1;
      hi_o    = div_rem;
      lo_o    = div_quo;
    end

    if (flush_i) begin
      whilo_o     = 1'b0;
      hi_o        = 32'd0;
      lo_o        = 32'd0;
      stall_req_o = 1'b0;
    end

    if (rst) begin
      wd_o        = 5'd0;
      wreg_o      = 1'b0;
      wdata_o     = 32'd0;
      whilo_o     = 1'b0;
      hi_o        = 32'd0;
      lo_o        = 32'd0;
      stall_req_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic [7:0]  aluop;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  wd;
  logic        wreg;
  logic        flush;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stall_req_o;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop),
    .reg1_i      (reg1),
    .reg2_i      (reg2),
    .wd_i        (wd),
    .wreg_i      (wreg),
    .flush_i     (flush),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .whilo_o     (whilo_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .stall_req_o (stall_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue a divide in the current cycle, expect `stalls` stalled cycles,
  // then the result, then an idle cycle with a nop op.
  task automatic do_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stalls,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    aluop = op;
    reg1  = a;
    reg2  = b;
    wreg  = 1'b1;
    #1;
    chk({tag, " wreg_o"}, {31'd0, wreg_o}, 32'd0);
    chk({tag, " wdata_o"}, wdata_o, 32'd0);
    for (int i = 0; i < stalls; i++) begin
      chk({tag, " stall"}, {31'd0, stall_req_o}, 32'd1);
      chk({tag, " whilo early"}, {31'd0, whilo_o}, 32'd0);
      cyc();
      #1;
    end
    chk({tag, " end stall"}, {31'd0, stall_req_o}, 32'd0);
    chk({tag, " end whilo"}, {31'd0, whilo_o}, 32'd1);
    chk({tag, " lo"}, lo_o, exp_lo);
    chk({tag, " hi"}, hi_o, exp_hi);
    cyc();
    aluop = 8'h00;
    #1;
    chk({tag, " idle stall"}, {31'd0, stall_req_o}, 32'd0);
    chk({tag, " idle whilo"}, {31'd0, whilo_o}, 32'd0);
    cyc();
  endtask

  initial begin
    rst   = 1'b1;
    aluop = 8'h25;
    reg1  = 32'h0000F0F0;
    reg2  = 32'h00FF00FF;
    wd    = 5'd5;
    wreg  = 1'b1;
    flush = 1'b0;

    // Reset holds all outputs at zero even with a live OR op presented.
    cyc();
    #1;
    chk("rst wdata", wdata_o, 32'd0);
    chk("rst wreg", {31'd0, wreg_o}, 32'd0);
    chk("rst wd", {27'd0, wd_o}, 32'd0);
    chk("rst stall", {31'd0, stall_req_o}, 32'd0);
    cyc();
    rst = 1'b0;
    #1;

    chk("or wdata", wdata_o, 32'h00FFF0FF);
    chk("or wd", {27'd0, wd_o}, 32'd5);
    chk("or wreg", {31'd0, wreg_o}, 32'd1);
    chk("or stall", {31'd0, stall_req_o}, 32'd0);
    chk("or whilo", {31'd0, whilo_o}, 32'd0);

    cyc();
    aluop = 8'h03; reg1 = 32'h00000024; reg2 = 32'h80000000; #1;
    chk("sra", wdata_o, 32'hF8000000);
    cyc();
    aluop = 8'h24; reg1 = 32'hFF00FF00; reg2 = 32'h0F0F0F0F; #1;
    chk("and", wdata_o, 32'h0F000F00);
    cyc();
    aluop = 8'h26; #1;
    chk("xor", wdata_o, 32'hF00FF00F);
    cyc();
    aluop = 8'h27; #1;
    chk("nor", wdata_o, 32'h00F000F0);
    cyc();
    aluop = 8'h7C; reg1 = 32'h00000021; reg2 = 32'h00000001; #1;
    chk("sll", wdata_o, 32'h00000002);
    cyc();
    aluop = 8'h02; reg1 = 32'h00000008; reg2 = 32'h80000000; #1;
    chk("srl", wdata_o, 32'h00800000);
    cyc();
    aluop = 8'h00; reg1 = 32'h12345678; reg2 = 32'h9ABCDEF0; wreg = 1'b1; #1;
    chk("unk wdata", wdata_o, 32'd0);
    chk("unk wreg", {31'd0, wreg_o}, 32'd1);
    chk("unk whilo", {31'd0, whilo_o}, 32'd0);
    cyc();
    aluop = 8'h18; reg1 = 32'hFFFFFFFF; reg2 = 32'h00000002; #1;
`ifdef EX_MULT_EN
    chk("mult whilo", {31'd0, whilo_o}, 32'd1);
    chk("mult hi", hi_o, 32'hFFFFFFFF);
    chk("mult lo", lo_o, 32'hFFFFFFFE);
    chk("mult wreg", {31'd0, wreg_o}, 32'd0);
`else
    chk("mult whilo", {31'd0, whilo_o}, 32'd0);
    chk("mult wdata", wdata_o, 32'd0);
`endif
    chk("mult stall", {31'd0, stall_req_o}, 32'd0);
    cyc();

    do_div("divu 100/7", 8'h1B, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    do_div("div -7/2", 8'h1A, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF);
    do_div("div 7/-2", 8'h1A, 32'd7, 32'hFFFFFFFE, 33, 32'hFFFFFFFD, 32'd1);
    do_div("div min/-1", 8'h1A, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'd0);
    do_div("divu big", 8'h1B, 32'hFFFFFFFF, 32'h00000010, 33, 32'h0FFFFFFF, 32'h0000000F);
    do_div("div by 0", 8'h1A, 32'd5, 32'd0, 2, 32'd0, 32'd0);

    // Flush at cycle 10 of a DIVU; a fresh DIVU at cycle 12 ends at cycle 45.
    aluop = 8'h1B; reg1 = 32'd100; reg2 = 32'd7; #1;
    for (int i = 0; i < 10; i++) begin
      cyc();
    end
    flush = 1'b1; #1;
    chk("flush stall", {31'd0, stall_req_o}, 32'd0);
    chk("flush whilo", {31'd0, whilo_o}, 32'd0);
    cyc();
    flush = 1'b0; aluop = 8'h00; #1;
    chk("post flush stall", {31'd0, stall_req_o}, 32'd0);
    chk("post flush whilo", {31'd0, whilo_o}, 32'd0);
    cyc();
    do_div("divu after flush", 8'h1B, 32'd1000, 32'd10, 33, 32'd100, 32'd0);

    // Reset in the middle of a divide.
    aluop = 8'h1B; reg1 = 32'd100; reg2 = 32'd7; #1;
    for (int i = 0; i < 5; i++) begin
      cyc();
    end
    rst = 1'b1; #1;
    chk("mid rst stall", {31'd0, stall_req_o}, 32'd0);
    chk("mid rst whilo", {31'd0, whilo_o}, 32'd0);
    chk("mid rst lo", lo_o, 32'd0);
    cyc();
    rst = 1'b0; aluop = 8'h00; #1;
    chk("after rst stall", {31'd0, stall_req_o}, 32'd0);
    chk("after rst whilo", {31'd0, whilo_o}, 32'd0);
    cyc();
    #1;
    chk("after rst idle", {31'd0, stall_req_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
